// File: rtl/r_exec_pkg.sv
// Shared types and constants for the R-format execute controller.
// FSM state encoding, MIPS opcode/funct values and ALU operation codes.
package r_exec_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_DECODE    = 3'd1,
    ST_READ      = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_WRITEBACK = 3'd4
  } state_e;

  localparam int unsigned ALU_OP_W = 4;

  localparam logic [5:0] OPCODE_RTYPE = 6'h00;

  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_XOR = 6'h26;
  localparam logic [5:0] FUNCT_NOR = 6'h27;
  localparam logic [5:0] FUNCT_SLT = 6'h2A;

  localparam logic [ALU_OP_W-1:0] ALU_OP_ADD = 4'b0000;
  localparam logic [ALU_OP_W-1:0] ALU_OP_SUB = 4'b0001;
  localparam logic [ALU_OP_W-1:0] ALU_OP_AND = 4'b0010;
  localparam logic [ALU_OP_W-1:0] ALU_OP_OR  = 4'b0011;
  localparam logic [ALU_OP_W-1:0] ALU_OP_XOR = 4'b0100;
  localparam logic [ALU_OP_W-1:0] ALU_OP_NOR = 4'b0101;
  localparam logic [ALU_OP_W-1:0] ALU_OP_SLT = 4'b0110;

  // shamt is deliberately not carried: this path never shifts.
  typedef struct packed {
    logic [5:0] opcode;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [5:0] funct;
  } rtype_t;

endpackage

// File: rtl/r_exec_controller_funct_decoder.sv
// Combinational funct -> ALU operation decoder with legality flag.
module r_funct_decoder
  import r_exec_pkg::*;
(
  input  logic [5:0]          funct,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                legal
);

  always_comb begin
    alu_op = '0;
    legal  = 1'b1;
    case (funct)
      FUNCT_ADD: alu_op = ALU_OP_ADD;
      FUNCT_SUB: alu_op = ALU_OP_SUB;
      FUNCT_AND: alu_op = ALU_OP_AND;
      FUNCT_OR:  alu_op = ALU_OP_OR;
      FUNCT_XOR: alu_op = ALU_OP_XOR;
      FUNCT_NOR: alu_op = ALU_OP_NOR;
      FUNCT_SLT: alu_op = ALU_OP_SLT;
      default:   legal  = 1'b0;
    endcase
  end

endmodule

// File: rtl/r_exec_controller.sv
// Five-state sequencer for one R-format instruction: decode, read, execute, writeback.
// Optional retired-instruction counter enabled by defining R_EXEC_PERF_CNT_EN.
module r_exec_controller
  import r_exec_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned OP_WIDTH   = 4
`ifdef R_EXEC_PERF_CNT_EN
  ,
  parameter int unsigned CNT_WIDTH  = 16
`endif
) (
  input  logic                  clk,
  input  logic                  reset_input,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic [31:0]           instr,
  output logic [ADDR_WIDTH-1:0] rs_address,
  output logic [ADDR_WIDTH-1:0] rt_address,
  output logic [ADDR_WIDTH-1:0] rd_address,
  input  logic [DATA_WIDTH-1:0] rs_data,
  input  logic [DATA_WIDTH-1:0] rt_data,
  output logic [OP_WIDTH-1:0]   ALU_operation,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  input  logic [DATA_WIDTH-1:0] alu_result,
  output logic                  write_enabled,
  output logic [DATA_WIDTH-1:0] wb_data,
  output logic                  done,
  output logic                  illegal
`ifdef R_EXEC_PERF_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0]  retired_count
`endif
);

  state_e                state_q, state_d;
  rtype_t                fields_q, fields_d;
  logic [ADDR_WIDTH-1:0] rs_addr_q, rs_addr_d;
  logic [ADDR_WIDTH-1:0] rt_addr_q, rt_addr_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [OP_WIDTH-1:0]   op_q, op_d;
  logic [DATA_WIDTH-1:0] alu_a_q, alu_a_d;
  logic [DATA_WIDTH-1:0] alu_b_q, alu_b_d;
  logic [DATA_WIDTH-1:0] wb_q, wb_d;
  logic                  we_q, we_d;
  logic                  done_q, done_d;
  logic                  illegal_q, illegal_d;
`ifdef R_EXEC_PERF_CNT_EN
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
`endif

  logic [5:0]          dec_funct;
  logic [ALU_OP_W-1:0] dec_op;
  logic                dec_legal;
  logic                unused_shamt;

  assign unused_shamt = ^instr[10:6];

  // One decoder serves both cycles: the incoming word at accept time (so the
  // illegal pulse can be registered into DECODE) and the latched word in DECODE.
  assign dec_funct = (state_q == ST_IDLE) ? instr[5:0] : fields_q.funct;

  r_funct_decoder u_funct_decoder (
    .funct  (dec_funct),
    .alu_op (dec_op),
    .legal  (dec_legal)
  );

  always_comb begin
    state_d   = state_q;
    fields_d  = fields_q;
    rs_addr_d = rs_addr_q;
    rt_addr_d = rt_addr_q;
    rd_addr_d = rd_addr_q;
    op_d      = op_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    wb_d      = wb_q;
    we_d      = 1'b0;
    done_d    = 1'b0;
    illegal_d = 1'b0;
`ifdef R_EXEC_PERF_CNT_EN
    cnt_d     = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (instr_valid) begin
          fields_d.opcode = instr[31:26];
          fields_d.rs     = instr[25:21];
          fields_d.rt     = instr[20:16];
          fields_d.rd     = instr[15:11];
          fields_d.funct  = instr[5:0];
          illegal_d       = (instr[31:26] != OPCODE_RTYPE) || !dec_legal;
          state_d         = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if ((fields_q.opcode != OPCODE_RTYPE) || !dec_legal) begin
          state_d = ST_IDLE;
        end else begin
          rs_addr_d = ADDR_WIDTH'(fields_q.rs);
          rt_addr_d = ADDR_WIDTH'(fields_q.rt);
          rd_addr_d = ADDR_WIDTH'(fields_q.rd);
          op_d      = OP_WIDTH'(dec_op);
          state_d   = ST_READ;
        end
      end
      ST_READ: begin
        alu_a_d = rs_data;
        alu_b_d = rt_data;
        state_d = ST_EXECUTE;
      end
      ST_EXECUTE: begin
        wb_d    = alu_result;
        we_d    = (fields_q.rd != 5'd0);
        done_d  = 1'b1;
`ifdef R_EXEC_PERF_CNT_EN
        cnt_d   = cnt_q + 1'b1;
`endif
        state_d = ST_WRITEBACK;
      end
      ST_WRITEBACK: state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_input) begin
    if (!reset_input) begin
      state_q   <= ST_IDLE;
      fields_q  <= '0;
      rs_addr_q <= '0;
      rt_addr_q <= '0;
      rd_addr_q <= '0;
      op_q      <= '0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      wb_q      <= '0;
      we_q      <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
`ifdef R_EXEC_PERF_CNT_EN
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      fields_q  <= fields_d;
      rs_addr_q <= rs_addr_d;
      rt_addr_q <= rt_addr_d;
      rd_addr_q <= rd_addr_d;
      op_q      <= op_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      wb_q      <= wb_d;
      we_q      <= we_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
`ifdef R_EXEC_PERF_CNT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  // Gated by reset so the handshake is closed while reset is held.
  assign instr_ready   = reset_input && (state_q == ST_IDLE);
  assign rs_address    = rs_addr_q;
  assign rt_address    = rt_addr_q;
  assign rd_address    = rd_addr_q;
  assign ALU_operation = op_q;
  assign alu_a         = alu_a_q;
  assign alu_b         = alu_b_q;
  assign wb_data       = wb_q;
  assign write_enabled = we_q;
  assign done          = done_q;
  assign illegal       = illegal_q;
`ifdef R_EXEC_PERF_CNT_EN
  assign retired_count = cnt_q;
`endif

endmodule

// File: tb/tb_r_exec_controller.sv
// Scoreboard bench for r_exec_controller: register file and ALU are modelled
// here, expected writebacks are queued at handshake and popped on done/illegal.
module tb_r_exec_controller;

`ifdef R_EXEC_PERF_CNT_EN
  localparam int unsigned CW = 3;
`endif

  logic        clk = 1'b0;
  logic        reset_input = 1'b0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [31:0] instr = '0;
  logic [4:0]  rs_address, rt_address, rd_address;
  logic [31:0] rs_data, rt_data;
  logic [3:0]  ALU_operation;
  logic [31:0] alu_a, alu_b, alu_result, wb_data;
  logic        write_enabled, done, illegal;
`ifdef R_EXEC_PERF_CNT_EN
  logic [CW-1:0] retired_count;
  logic [CW-1:0] exp_cnt = '0;
`endif

  int unsigned checks = 0;
  int unsigned errors = 0;

  typedef struct {
    bit          ill;
    logic [4:0]  rd;
    logic [31:0] data;
    bit          we;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  r_exec_controller #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (5),
    .OP_WIDTH   (4)
`ifdef R_EXEC_PERF_CNT_EN
    ,
    .CNT_WIDTH  (CW)
`endif
  ) dut (
    .clk           (clk),
    .reset_input   (reset_input),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr         (instr),
    .rs_address    (rs_address),
    .rt_address    (rt_address),
    .rd_address    (rd_address),
    .rs_data       (rs_data),
    .rt_data       (rt_data),
    .ALU_operation (ALU_operation),
    .alu_a         (alu_a),
    .alu_b         (alu_b),
    .alu_result    (alu_result),
    .write_enabled (write_enabled),
    .wb_data       (wb_data),
    .done          (done),
    .illegal       (illegal)
`ifdef R_EXEC_PERF_CNT_EN
    ,
    .retired_count (retired_count)
`endif
  );

  function automatic logic [31:0] rf_val(input logic [4:0] a);
    if (a < 5'd8) return {27'd0, a};
    return 32'h8000_1230 ^ {a, 27'd0} ^ {27'd0, a};
  endfunction

  assign rs_data = rf_val(rs_address);
  assign rt_data = rf_val(rt_address);

  always_comb begin
    case (ALU_operation)
      4'd0:    alu_result = alu_a + alu_b;
      4'd1:    alu_result = alu_a - alu_b;
      4'd2:    alu_result = alu_a & alu_b;
      4'd3:    alu_result = alu_a | alu_b;
      4'd4:    alu_result = alu_a ^ alu_b;
      4'd5:    alu_result = ~(alu_a | alu_b);
      4'd6:    alu_result = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
      default: alu_result = 32'hBAD0_BAD0;
    endcase
  end

  function automatic logic [3:0] ref_op(input logic [5:0] f);
    case (f)
      6'h20: return 4'b0000;
      6'h22: return 4'b0001;
      6'h24: return 4'b0010;
      6'h25: return 4'b0011;
      6'h26: return 4'b0100;
      6'h27: return 4'b0101;
      6'h2A: return 4'b0110;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic bit ref_legal(input logic [31:0] w);
    return (w[31:26] == 6'h00) && (ref_op(w[5:0]) != 4'b1111);
  endfunction

  function automatic logic [31:0] ref_result(input logic [5:0] f, input logic [31:0] a,
                                             input logic [31:0] b);
    case (f)
      6'h20: return a + b;
      6'h22: return a - b;
      6'h24: return a & b;
      6'h25: return a | b;
      6'h26: return a ^ b;
      6'h27: return ~(a | b);
      6'h2A: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] mk_r(input logic [4:0] rs, input logic [4:0] rt,
                                       input logic [4:0] rd, input logic [5:0] f);
    return {6'h00, rs, rt, rd, 5'd0, f};
  endfunction

  task automatic push_expect(input logic [31:0] w);
    exp_t e;
    e.ill  = !ref_legal(w);
    e.rd   = w[15:11];
    e.data = ref_result(w[5:0], rf_val(w[25:21]), rf_val(w[20:16]));
    e.we   = (w[15:11] != 5'd0);
    sb.push_back(e);
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset_input && (illegal || done || write_enabled)) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event illegal=%0b done=%0b we=%0b required none",
                   illegal, done, write_enabled);
        end else begin
          e = sb.pop_front();
          if ({illegal, done, write_enabled} !== (e.ill ? 3'b100 : {2'b01, e.we})) begin
            errors++;
            $display("FAIL event_flags got ill/done/we=%b required %b", {illegal, done, write_enabled},
                     (e.ill ? 3'b100 : {2'b01, e.we}));
          end
          if (!e.ill) begin
            checks++;
            if ({rd_address, wb_data} !== {e.rd, e.data}) begin
              errors++;
              $display("FAIL writeback got rd=%0d data=%h required rd=%0d data=%h",
                       rd_address, wb_data, e.rd, e.data);
            end
          end
        end
`ifdef R_EXEC_PERF_CNT_EN
        if (done) begin
          exp_cnt++;
          checks++;
          if (retired_count !== exp_cnt) begin
            errors++;
            $display("FAIL retired_count got %0d required %0d", retired_count, exp_cnt);
          end
        end
`endif
      end
    end
  endtask

  // Called at a negedge; returns at the negedge of cycle 1 with instr_valid still high.
  task automatic accept(input logic [31:0] w, output time t, output bit ok);
    instr       = w;
    instr_valid = 1'b1;
    ok          = 1'b0;
    t           = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (instr_ready) begin
        @(posedge clk);
        t  = $time;
        push_expect(w);
        ok = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout instr=%h instr_ready=%0b required 1", w, instr_ready);
      instr_valid = 1'b0;
    end else begin
      @(negedge clk);
    end
  endtask

  task automatic run_legal(input logic [31:0] w);
    time t;
    bit  ok;
    accept(w, t, ok);
    instr_valid = 1'b0;
    if (!ok) return;
    checks++;
    if ({instr_ready, illegal} !== 2'b00) begin
      errors++;
      $display("FAIL decode_cycle got ready/illegal=%b required 00", {instr_ready, illegal});
    end
    @(negedge clk);
    checks++;
    if ({rs_address, rt_address, rd_address} !== {w[25:21], w[20:16], w[15:11]}) begin
      errors++;
      $display("FAIL read_addr got %0d/%0d/%0d required %0d/%0d/%0d", rs_address, rt_address,
               rd_address, w[25:21], w[20:16], w[15:11]);
    end
    @(negedge clk);
    checks++;
    if ({ALU_operation, alu_a, alu_b} !== {ref_op(w[5:0]), rf_val(w[25:21]), rf_val(w[20:16])}) begin
      errors++;
      $display("FAIL execute got op=%b a=%h b=%h required op=%b a=%h b=%h", ALU_operation, alu_a,
               alu_b, ref_op(w[5:0]), rf_val(w[25:21]), rf_val(w[20:16]));
    end
    @(negedge clk);
    checks++;
    if ({done, write_enabled} !== {1'b1, (w[15:11] != 5'd0)}) begin
      errors++;
      $display("FAIL wb_cycle got done/we=%b required %b", {done, write_enabled},
               {1'b1, (w[15:11] != 5'd0)});
    end
    @(negedge clk);
    checks++;
    if ({instr_ready, done, write_enabled, rd_address} !== {3'b100, w[15:11]}) begin
      errors++;
      $display("FAIL idle_hold got ready/done/we=%b rd=%0d required 100 rd=%0d",
               {instr_ready, done, write_enabled}, rd_address, w[15:11]);
    end
  endtask

  task automatic run_illegal(input logic [31:0] w);
    time t;
    bit  ok;
    accept(w, t, ok);
    instr_valid = 1'b0;
    if (!ok) return;
    checks++;
    if ({illegal, done, write_enabled} !== 3'b100) begin
      errors++;
      $display("FAIL illegal_pulse got ill/done/we=%b required 100", {illegal, done, write_enabled});
    end
    @(negedge clk);
    checks++;
    if ({instr_ready, illegal} !== 2'b10) begin
      errors++;
      $display("FAIL illegal_recover got ready/illegal=%b required 10", {instr_ready, illegal});
    end
  endtask

  task automatic test_reset();
    reset_input = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({instr_ready, rs_address, rt_address, rd_address, ALU_operation, alu_a, alu_b,
         write_enabled, wb_data, done, illegal} !== '0) begin
      errors++;
      $display("FAIL reset_state got ready=%0b we=%0b done=%0b wb=%h required all zero",
               instr_ready, write_enabled, done, wb_data);
    end
    #2 reset_input = 1'b1;
    #1;
    checks++;
    if (instr_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready got %0b required 1", instr_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_add();
    run_legal(32'h0022_1820);
    run_legal(32'h0022_1960);
  endtask

  task automatic test_sub();
    run_legal(32'h0086_2822);
  endtask

  task automatic test_logic_ops();
    logic [5:0] fl[5] = '{6'h24, 6'h25, 6'h26, 6'h27, 6'h2A};
    for (int i = 0; i < 5; i++) run_legal(mk_r(5'd9, 5'd17, 5'd12, fl[i]));
    run_legal(mk_r(5'd17, 5'd9, 5'd30, 6'h2A));
  endtask

  task automatic test_illegal();
    run_illegal(32'h0022_183F);
    run_illegal(32'h2022_1820);
    run_illegal(mk_r(5'd1, 5'd2, 5'd3, 6'h21));
  endtask

  task automatic test_rd_zero();
    run_legal(32'h0022_0020);
  endtask

  task automatic test_back_to_back();
    time t0, t1;
    bit  ok0, ok1;
    accept(mk_r(5'd3, 5'd4, 5'd6, 6'h20), t0, ok0);
    accept(mk_r(5'd6, 5'd1, 5'd7, 6'h22), t1, ok1);
    instr_valid = 1'b0;
    if (ok0 && ok1) begin
      checks++;
      if (t1 - t0 !== 50) begin
        errors++;
        $display("FAIL b2b_spacing got %0t required 50", t1 - t0);
      end
    end
    repeat (5) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL b2b_drain got %0d pending required 0", sb.size());
    end
  endtask

  task automatic test_reset_mid();
    time t;
    bit  ok;
    accept(mk_r(5'd9, 5'd17, 5'd7, 6'h20), t, ok);
    instr_valid = 1'b0;
    repeat (2) @(negedge clk);
    #2 reset_input = 1'b0;
    #1;
    checks++;
    if ({instr_ready, rs_address, rt_address, rd_address, ALU_operation, alu_a, alu_b,
         write_enabled, wb_data, done, illegal} !== '0) begin
      errors++;
      $display("FAIL mid_reset_outputs got rs=%0d op=%b a=%h we=%0b done=%0b required all zero",
               rs_address, ALU_operation, alu_a, write_enabled, done);
    end
    sb.delete();
`ifdef R_EXEC_PERF_CNT_EN
    exp_cnt = '0;
`endif
    repeat (2) @(negedge clk);
    #2 reset_input = 1'b1;
    @(negedge clk);
    checks++;
    if ({instr_ready, done, write_enabled} !== 3'b100) begin
      errors++;
      $display("FAIL mid_reset_release got ready/done/we=%b required 100",
               {instr_ready, done, write_enabled});
    end
    repeat (6) @(negedge clk);
    run_legal(mk_r(5'd2, 5'd5, 5'd4, 6'h25));
  endtask

`ifdef R_EXEC_PERF_CNT_EN
  task automatic test_perf_cnt();
    logic [CW-1:0] base;
    base = exp_cnt;
    run_legal(32'h0022_1820);
    run_legal(32'h0086_2822);
    run_legal(32'h0022_0020);
    run_illegal(32'h0022_183F);
    checks++;
    if (retired_count !== CW'(base + 3)) begin
      errors++;
      $display("FAIL perf_three got %0d required %0d", retired_count, CW'(base + 3));
    end
    base = exp_cnt;
    for (int i = 0; i < (1 << CW); i++) run_legal(mk_r(5'd1, 5'd2, 5'd3, 6'h20));
    checks++;
    if (retired_count !== base) begin
      errors++;
      $display("FAIL perf_wrap got %0d required %0d", retired_count, base);
    end
  endtask
`endif

  initial begin
    fork
      monitor();
      begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
      end
    join_none
    test_reset();
    test_add();
    test_sub();
    test_logic_ops();
    test_illegal();
    test_rd_zero();
    test_back_to_back();
    test_reset_mid();
`ifdef R_EXEC_PERF_CNT_EN
    test_perf_cnt();
`endif
    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL final_drain got %0d pending required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
